// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the word-addressed data memory with posted-write
// buffer: default geometry, the buffer entry layout, the drain FSM state
// type and the byte-address to word-index helper.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEPTH_DEF        = 4;   // write-buffer entries
    localparam int AW_DEF           = 6;   // word-address bits
    localparam int DRAIN_CYCLES_DEF = 2;   // cycles a head waits before draining

    // Entries carry the widest possible word index (Addr[31:2]) so the struct
    // does not depend on AW; bits above AW are always zero and fold away.
    localparam int IDX_W = 30;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
        logic [31:0]      data;
    } wbuf_entry_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_WAIT = 1'b1
    } drain_state_e;

    // Word index = Addr[aw+1:2]; byte offset and bits above the RAM are dropped,
    // so addresses that differ only there alias to the same word.
    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr,
                                                   input int          aw);
        logic [IDX_W-1:0] mask;
        for (int i = 0; i < IDX_W; i++) begin
            mask[i] = (i < aw);
        end
        return addr[31:2] & mask;
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
// In-order circular store buffer with youngest-match forwarding.
//
// Ports:
//   clk, reset        clock, async active-high reset (empties the buffer)
//   push_i            enqueue {push_index_i, push_data_i} at tail (ignored when full)
//   pop_i             dequeue the head (ignored when empty)
//   rd_index_i        word index searched by the load path
//   full_o, count_o   occupancy
//   head_valid_o,
//   head_index_o,
//   head_data_o       oldest entry, next to be written to RAM
//   hit_o, hit_data_o youngest valid entry matching rd_index_i
// -----------------------------------------------------------------------------
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [IDX_W-1:0]       push_index_i,
    input  logic [31:0]            push_data_i,
    input  logic                   pop_i,
    input  logic [IDX_W-1:0]       rd_index_i,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   head_valid_o,
    output logic [AW-1:0]          head_index_o,
    output logic [31:0]            head_data_o,
    output logic                   hit_o,
    output logic [31:0]            hit_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t      entries_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;
    logic [DEPTH-1:0] match;
    logic [PW-1:0]    age_slot;

    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;   // idle, or push+pop cancel out
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Push and pop never target the same slot: that would need the
            // buffer to be both full (push blocked) and empty (pop blocked).
            if (do_pop) begin
                entries_q[rd_ptr_q].valid <= 1'b0;
            end
            if (do_push) begin
                entries_q[wr_ptr_q] <= '{valid: 1'b1, index: push_index_i, data: push_data_i};
            end
        end
    end

    // Every slot compares against the load index in parallel.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entries_q[i].valid && (entries_q[i].index == rd_index_i);
        end
    end

    // Walk slots oldest to youngest so the last hit seen is the youngest store.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        age_slot   = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            age_slot = rd_ptr_q + PW'(k);
            if (match[age_slot]) begin
                hit_o      = 1'b1;
                hit_data_o = entries_q[age_slot].data;
            end
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = entries_q[rd_ptr_q].valid;
    assign head_index_o = entries_q[rd_ptr_q].index[AW-1:0];
    assign head_data_o  = entries_q[rd_ptr_q].data;

endmodule

// File: rtl/dmem_wbuf.sv
// -----------------------------------------------------------------------------
// dmem_wbuf
// Word-addressed data memory behind a posted-write buffer. Stores are queued
// and drained to RAM in order, one every DRAIN_CYCLES cycles; loads forward
// from the youngest buffered store to the same word, else read RAM.
//
// Ports:
//   clk        system clock
//   reset      async active-high; discards pending stores (RAM keeps contents)
//   MemWrite   store request this cycle
//   Addr       byte address (word index = Addr[AW+1:2])
//   WriteData  store data
//   ReadData   combinational load data
//   Stall      store rejected because the buffer is full; re-present it
//   Empty      no pending stores
//   Count      number of pending stores
// -----------------------------------------------------------------------------
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int AW           = AW_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic [31:0]            Addr,
    input  logic [31:0]            WriteData,
    output logic [31:0]            ReadData,
    output logic                   Stall,
    output logic                   Empty,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [IDX_W-1:0] idx;
    logic             full;
    logic [CW-1:0]    count;
    logic             accept;
    logic             head_valid;
    logic [AW-1:0]    head_index;
    logic [31:0]      head_data;
    logic             hit;
    logic [31:0]      hit_data;

    drain_state_e     state_q;
    logic [TW-1:0]    timer_q;
    logic             drain_fire;

    logic [31:0]      ram_q [2**AW];

    assign idx = word_index(Addr, AW);

    // Full is judged on the current occupancy even if the head drains this
    // same edge; costs at most one extra stall cycle and keeps Stall shallow.
    assign accept = MemWrite && !full;
    assign Stall  = MemWrite && full;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (accept),
        .push_index_i (idx),
        .push_data_i  (WriteData),
        .pop_i        (drain_fire),
        .rd_index_i   (idx),
        .full_o       (full),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_index_o (head_index),
        .head_data_o  (head_data),
        .hit_o        (hit),
        .hit_data_o   (hit_data)
    );

    assign drain_fire = (state_q == DRAIN_WAIT) && head_valid
                     && (timer_q == TW'(DRAIN_CYCLES - 1));

    // Drain FSM: the timer measures how long the current head has waited and
    // restarts whenever a new entry becomes head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DRAIN_IDLE;
            timer_q <= '0;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    timer_q <= '0;
                    if (accept) state_q <= DRAIN_WAIT;
                end
                DRAIN_WAIT: begin
                    if (drain_fire) begin
                        timer_q <= '0;
                        // Last entry leaving with nothing arriving behind it.
                        if ((count == CW'(1)) && !accept) state_q <= DRAIN_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: the RAM array has no reset; clearing it is neither required nor
    // cheap, and its contents must survive a buffer reset.
    always_ff @(posedge clk) begin
        if (drain_fire) begin
            ram_q[head_index] <= head_data;
        end
    end

    // A load racing the drain of its own word still sees the buffered value,
    // which is the same value RAM takes at that edge.
    assign ReadData = hit ? hit_data : ram_q[idx[AW-1:0]];
    assign Empty    = (count == '0);
    assign Count    = count;

endmodule

// File: tb/tb_dmem_wbuf.sv
// -----------------------------------------------------------------------------
// tb_dmem_wbuf
// Scoreboard bench: the driver computes each cycle's expected outputs from a
// queue-level reference model and pushes them; a monitor pops and compares at
// the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_wbuf;

    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int DC    = 2;
    localparam int WORDS = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;
    logic [2:0]  Count;

    dmem_wbuf #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Empty     (Empty),
        .Count     (Count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } store_t;

    typedef struct {
        logic [31:0] rd;
        bit          rd_chk;
        bit          stall;
        int          count;
        bit          empty;
    } exp_t;

    store_t      pend[$];          // pending stores, oldest first
    int          head_wait = 0;    // cycles the current head has waited
    logic [31:0] ram_m   [WORDS];
    bit          ram_known [WORDS];

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % WORDS;
    endfunction

    function automatic exp_t predict(input bit mw, input logic [31:0] a);
        exp_t        e;
        int unsigned i;
        i        = widx(a);
        e.rd     = '0;
        e.rd_chk = 1'b0;
        if (ram_known[i]) begin
            e.rd     = ram_m[i];
            e.rd_chk = 1'b1;
        end
        // Youngest pending store to this word wins.
        foreach (pend[k]) begin
            if (pend[k].idx == i) begin
                e.rd     = pend[k].data;
                e.rd_chk = 1'b1;
            end
        end
        e.count = pend.size();
        e.empty = (pend.size() == 0);
        e.stall = mw && (pend.size() == DEPTH);
        return e;
    endfunction

    // Advance the model across one rising edge.
    task automatic model_edge(input bit mw, input logic [31:0] a, input logic [31:0] wd);
        bit     pop;
        bit     push;
        store_t s;
        push = mw && (pend.size() < DEPTH);
        pop  = (pend.size() > 0) && (head_wait == DC - 1);
        if (pop) begin
            s = pend.pop_front();
            ram_m[s.idx]     = s.data;
            ram_known[s.idx] = 1'b1;
            head_wait        = 0;
        end else if (pend.size() > 0) begin
            head_wait++;
        end
        if (push) begin
            s.idx  = widx(a);
            s.data = wd;
            pend.push_back(s);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.rd_chk) check("ReadData", ReadData, e.rd);
                check("Stall", {31'b0, Stall}, {31'b0, e.stall});
                check("Count", {29'b0, Count}, e.count);
                check("Empty", {31'b0, Empty}, {31'b0, e.empty});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input bit mw, input logic [31:0] a, input logic [31:0] wd,
                         output bit stalled);
        exp_t e;
        @(posedge clk);
        #1;
        MemWrite  = mw;
        Addr      = a;
        WriteData = wd;
        e = predict(mw, a);
        exp_q.push_back(e);
        stalled = e.stall;
        model_edge(mw, a, wd);
    endtask

    // A stalled store is re-presented unchanged until accepted.
    task automatic store(input logic [31:0] a, input logic [31:0] wd);
        bit st;
        int tries;
        tries = 0;
        do begin
            cycle(1'b1, a, wd, st);
            tries++;
        end while (st && tries < 20);
    endtask

    task automatic idle(input logic [31:0] a);
        bit st;
        cycle(1'b0, a, $urandom, st);
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next edge.
    task automatic do_reset(input logic [31:0] a);
        exp_t e;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        Addr     = a;
        #1 reset = 1'b1;
        pend.delete();
        head_wait = 0;
        e = predict(1'b0, a);
        exp_q.push_back(e);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : driver
        logic [31:0] a;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
        for (int i = 0; i < WORDS; i++) ram_known[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Give every RAM word a known value; word 5 gets the marker.
        for (int i = 0; i < WORDS; i++) begin
            store(32'(i) << 2, (i == 5) ? 32'hCAFEF00D : $urandom);
        end
        repeat (DEPTH * DC + 2) idle(32'h14);

        // Reset state: empty buffer, load served from RAM.
        do_reset(32'h14);
        idle(32'h14);

        // Single store, forwarded then drained.
        store(32'h14, 32'h11111111);
        repeat (4) idle(32'h14);

        // Same word twice: youngest value everywhere.
        store(32'h08, 32'h0000000A);
        store(32'h08, 32'h0000000B);
        repeat (6) idle(32'h08);

        // Back-to-back stores long enough to fill the buffer and stall.
        for (int k = 0; k < 8; k++) store(32'h40 + 32'(4 * k), 32'h5000 + 32'(k));
        for (int k = 0; k < 8; k++) idle(32'h40 + 32'(4 * k));
        repeat (DEPTH * DC) idle(32'h40);
        for (int k = 0; k < 8; k++) idle(32'h40 + 32'(4 * k));

        // Reset with several stores pending, then read the words back.
        for (int k = 0; k < 4; k++) store(32'h80 + 32'(4 * k), 32'hDEAD0000 + 32'(k));
        do_reset(32'h80);
        for (int k = 0; k < 4; k++) idle(32'h80 + 32'(4 * k));

        // Address aliasing: 0x100 and 0x000 are both word 0.
        store(32'h100, 32'h0A11A5ED);
        repeat (4) idle(32'h000);

        // Randomized traffic, biased toward a few words for forwarding hits.
        for (int n = 0; n < 600; n++) begin
            a = $urandom;
            if ($urandom_range(1) == 1) a = (a & ~32'h0000_00FC) | (32'($urandom_range(7)) << 2);
            if ($urandom_range(99) < 2)      do_reset(a);
            else if ($urandom_range(1) == 1) store(a, $urandom);
            else                             idle(a);
        end
        repeat (DEPTH * DC + 2) idle($urandom);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
